volume_scaler: RTL and testbench

VOLUME_SCALER -- requirements
Module: volume_scaler

---
 rtl/volume_pkg.sv | 29 ++
 rtl/volume_gain_ramp.sv | 30 +++
 rtl/volume_scaler.sv | 69 ++++++
 tb/tb_volume_scaler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/volume_pkg.sv
// Shared constants for the volume scaler: sample/gain widths and the
// level-to-gain table (gain in 1/16 units).
package volume_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int GAIN_W       = 5;
  localparam int GAIN_SHIFT   = 4;

  localparam logic [GAIN_W-1:0] GAIN_FULL = 5'd16;
  localparam logic [GAIN_W-1:0] GAIN_LVL0 = 5'd0;
  localparam logic [GAIN_W-1:0] GAIN_LVL1 = 5'd2;
  localparam logic [GAIN_W-1:0] GAIN_LVL2 = 5'd4;
  localparam logic [GAIN_W-1:0] GAIN_LVL3 = 5'd8;
  localparam logic [GAIN_W-1:0] GAIN_LVL4 = 5'd12;
  localparam logic [GAIN_W-1:0] GAIN_LVL5 = GAIN_FULL;

  // Out-of-range levels (6, 7) clamp to full scale.
  function automatic logic [GAIN_W-1:0] level_to_gain(input logic [2:0] level);
    case (level)
      3'd0:    level_to_gain = GAIN_LVL0;
      3'd1:    level_to_gain = GAIN_LVL1;
      3'd2:    level_to_gain = GAIN_LVL2;
      3'd3:    level_to_gain = GAIN_LVL3;
      3'd4:    level_to_gain = GAIN_LVL4;
      default: level_to_gain = GAIN_LVL5;
    endcase
  endfunction

endpackage

// File: rtl/volume_gain_ramp.sv
// Target gain decode plus a current-gain register that steps one unit toward
// the target each time step is asserted, so volume changes never click.
module volume_gain_ramp
  import volume_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        level,
  input  logic              step,
  output logic [GAIN_W-1:0] gain,
  output logic              muted,
  output logic              ramping
);

  logic [GAIN_W-1:0] target;

  assign target  = level_to_gain(level);
  assign muted   = (gain == '0) && (target == '0);
  assign ramping = (gain != target);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gain <= '0;
    end else if (step && ramping) begin
      if (gain < target) gain <= gain + 5'd1;
      else               gain <= gain - 5'd1;
    end
  end

endmodule

// File: rtl/volume_scaler.sv
// Two-stage valid/ready pipeline that multiplies each sample by the ramped
// gain (1/16 units) with floor rounding; gain advances once per accepted sample.
module volume_scaler
  import volume_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 level,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  input  logic                       out_ready,
  output logic                       muted,
  output logic                       ramping
);

  localparam int PW = SAMPLE_W + 6;

  logic                       advance, accept;
  logic [GAIN_W-1:0]          gain;
  logic                       s1_valid;
  logic signed [SAMPLE_W-1:0] s1_sample;
  logic [GAIN_W-1:0]          s1_gain;
  logic signed [PW-1:0]       sample_ext, gain_ext, product;
  logic signed [SAMPLE_W-1:0] scaled;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  volume_gain_ramp u_ramp (
    .clock   (clock),
    .reset   (reset),
    .level   (level),
    .step    (accept),
    .gain    (gain),
    .muted   (muted),
    .ramping (ramping)
  );

  // Gain <= 16 keeps the shifted product within SAMPLE_W bits, so truncation is exact.
  assign sample_ext = {{(PW-SAMPLE_W){s1_sample[SAMPLE_W-1]}}, s1_sample};
  assign gain_ext   = {{(PW-GAIN_W){1'b0}}, s1_gain};
  assign product    = sample_ext * gain_ext;
  assign scaled     = SAMPLE_W'(product >>> GAIN_SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_sample  <= '0;
      s1_gain    <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else if (advance) begin
      s1_valid  <= accept;
      out_valid <= s1_valid;
      if (accept) begin
        s1_sample <= in_sample;
        s1_gain   <= gain;
      end
      if (s1_valid) out_sample <= scaled;
    end
  end

endmodule

// File: tb/tb_volume_scaler.sv
// Directed bench for volume_scaler: ramp sequences, full-scale limits, floor
// rounding, backpressure and asynchronous reset with hand-computed values.
`timescale 1ns/1ps
module tb_volume_scaler;

  logic               clock, reset;
  logic [2:0]         level;
  logic               in_valid, in_ready;
  logic signed [15:0] in_sample;
  logic               out_valid, out_ready;
  logic signed [15:0] out_sample;
  logic               muted, ramping;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [15:0] got[$];

  volume_scaler #(.SAMPLE_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .level      (level),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .out_ready  (out_ready),
    .muted      (muted),
    .ramping    (ramping)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record each output handshake once; inputs are stable at the falling edge.
  always @(negedge clock)
    if (!reset && out_valid && out_ready) got.push_back(out_sample);

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
  endtask

  task automatic send(input int v);
    in_valid  = 1'b1;
    in_sample = 16'(v);
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; level = 3'd1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;

    // Reset state and combinational status
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ramping_l1", ramping, 1);
    chk("rst_muted_l1", muted, 0);
    level = 3'd0; #1;
    chk("rst_muted_l0", muted, 1);
    chk("rst_ramping_l0", ramping, 0);
    level = 3'd1;
    tick();
    reset = 1'b0;

    // Level 1 ramp: 1000 -> 0, 62, 125, 125, 125
    got.delete();
    send(1000);
    chk("l1_ramping_1", ramping, 1);
    chk("l1_latency_1", out_valid, 0);
    send(1000);
    chk("l1_ramping_2", ramping, 0);
    chk("l1_latency_2", out_valid, 1);
    repeat (3) send(1000);
    drain(3);
    chk("l1_count", got.size(), 5);
    chk("l1_o0", got[0], 0);
    chk("l1_o1", got[1], 62);
    chk("l1_o2", got[2], 125);
    chk("l1_o3", got[3], 125);
    chk("l1_o4", got[4], 125);

    // Full-scale limits at gain 16
    do_reset();
    level = 3'd5;
    repeat (16) send(0);
    drain(3);
    chk("full_ramping", ramping, 0);
    got.delete();
    send(-32768);
    send(32767);
    drain(3);
    chk("full_count", got.size(), 2);
    chk("full_min", got[0], -32768);
    chk("full_max", got[1], 32767);

    // Floor rounding at gain 1
    do_reset();
    level = 3'd1;
    got.delete();
    send(0);
    send(-1000);
    drain(3);
    chk("floor_count", got.size(), 2);
    chk("floor_neg", got[1], -63);

    // Level 7 saturates at 16; input 16 makes output equal the gain used
    do_reset();
    level = 3'd7;
    got.delete();
    repeat (20) send(16);
    drain(3);
    chk("l7_count", got.size(), 20);
    for (int k = 0; k < 20; k++) chk($sformatf("l7_o%0d", k), got[k], (k < 16) ? k : 16);
    chk("l7_ramping", ramping, 0);
    chk("l7_muted", muted, 0);

    // Backpressure: 1..8 with out_ready low for 5 cycles
    got.delete();
    begin
      int idx = 1;
      int cyc = 0;
      logic rdy;
      logic signed [15:0] held = '0;
      while (idx <= 8 && cyc < 100) begin
        out_ready = !(cyc >= 3 && cyc < 8);
        in_valid  = 1'b1;
        in_sample = 16'(idx);
        #1;
        rdy = in_ready;
        if (!out_ready) begin
          chk("bp_stall_valid", out_valid, 1);
          chk("bp_in_ready_low", in_ready, 0);
          if (cyc == 3) held = out_sample;
          else chk("bp_stable", out_sample, held);
        end
        @(posedge clock);
        if (rdy) idx++;
        #1;
        cyc++;
      end
      chk("bp_done", idx, 9);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain(3);
    chk("bp_count", got.size(), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("bp_o%0d", k), got[k], k + 1);

    // Mid-ramp target change: 16 -> toward 0, then toward 8
    level = 3'd5;
    got.delete();
    level = 3'd0;
    repeat (6) begin send(16); chk("rr_muted_a", muted, 0); end
    level = 3'd3;
    repeat (4) begin send(16); chk("rr_muted_b", muted, 0); end
    drain(3);
    chk("rr_muted_end", muted, 0);
    chk("rr_ramping_end", ramping, 0);
    chk("rr_count", got.size(), 10);
    begin
      int exp_rr[10] = '{16, 15, 14, 13, 12, 11, 10, 9, 8, 8};
      for (int k = 0; k < 10; k++) chk($sformatf("rr_o%0d", k), got[k], exp_rr[k]);
    end

    // Async reset pulse with both stages full
    do_reset();
    level = 3'd5;
    out_ready = 1'b0;
    in_valid = 1'b1; in_sample = 16'sd1234;
    tick();
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_valid_drop", out_valid, 0);
    chk("ar_sample_zero", out_sample, 0);
    chk("ar_in_ready", in_ready, 1);
    #1;
    reset = 1'b0;
    got.delete();
    out_ready = 1'b1;
    tick();
    send(500);
    send(500);
    drain(3);
    chk("ar_count", got.size(), 2);
    chk("ar_first", got[0], 0);
    chk("ar_second", got[1], 31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
